// File: rtl/rob_recovery_walker.sv
// rob_recovery_walker
//   Sequences ROB recovery after a branch mispredict or a memory-order violation. Walks the ROB
//   from the youngest entry (rob_tail) toward the offender, two entries per cycle, restoring the
//   rename map and invalidating each walked entry. Reports the new tail and flush count on done.
// Ports
//   clk, reset                                  clock, synchronous active-high reset
//   prmiss, prmiss_rob_idx                      mispredict request (flushes strictly younger)
//   violation_detected, violation_rob_idx       order violation (flushes offender and younger)
//   rob_tail                                    youngest allocated ROB index
//   rd_idx_1/2, rd_dst_1/2, rd_ori_1/2          ROB read ports (slot 1 is the younger entry)
//   restore_valid/arch/phy_1/2                  rename-map restore, slot 1 applied first
//   flush_valid_1/2                             invalidate ROB entry at rd_idx_x
//   busy, recover_done, new_tail, flush_count   status and completion report
module rob_recovery_walker #(
    parameter int unsigned ROB_NUM     = 64,
    parameter int unsigned ROB_SEL     = $clog2(ROB_NUM),
    parameter int unsigned REG_SEL     = 5,
    parameter int unsigned PHY_REG_SEL = 7
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   prmiss,
    input  logic [ROB_SEL-1:0]     prmiss_rob_idx,
    input  logic                   violation_detected,
    input  logic [ROB_SEL-1:0]     violation_rob_idx,
    input  logic [ROB_SEL-1:0]     rob_tail,
    output logic [ROB_SEL-1:0]     rd_idx_1,
    output logic [ROB_SEL-1:0]     rd_idx_2,
    input  logic [REG_SEL-1:0]     rd_dst_1,
    input  logic [REG_SEL-1:0]     rd_dst_2,
    input  logic [PHY_REG_SEL-1:0] rd_ori_1,
    input  logic [PHY_REG_SEL-1:0] rd_ori_2,
    output logic                   restore_valid_1,
    output logic                   restore_valid_2,
    output logic [REG_SEL-1:0]     restore_arch_1,
    output logic [REG_SEL-1:0]     restore_arch_2,
    output logic [PHY_REG_SEL-1:0] restore_phy_1,
    output logic [PHY_REG_SEL-1:0] restore_phy_2,
    output logic                   flush_valid_1,
    output logic                   flush_valid_2,
    output logic                   busy,
    output logic                   recover_done,
    output logic [ROB_SEL-1:0]     new_tail,
    output logic [ROB_SEL:0]       flush_count
);

    typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

    state_e           state_q, state_d;
    logic [ROB_SEL-1:0] start_q, start_d;
    logic [ROB_SEL-1:0] tgt_q, tgt_d;
    logic [ROB_SEL:0]   total_q, total_d;
    logic [ROB_SEL:0]   walked_q, walked_d;

    logic [ROB_SEL-1:0] base, diff_p, diff_v, tgt_req;
    logic [ROB_SEL:0]   n_p, n_v, n_req;
    logic               req_any, slot1, slot2;

    // Request decode. In WALK distances are measured from the latched start so an older
    // follow-up request can be compared directly against the running total.
    always_comb begin
        base    = (state_q == StWalk) ? start_q : rob_tail;
        diff_p  = prmiss_rob_idx - base;
        diff_v  = violation_rob_idx - base;
        n_p     = {1'b0, diff_p};
        n_v     = {1'b0, diff_v} + (ROB_SEL+1)'(1);
        req_any = prmiss | violation_detected;
        if (prmiss && (!violation_detected || n_p >= n_v)) begin
            n_req   = n_p;
            tgt_req = prmiss_rob_idx;
        end else begin
            n_req   = n_v;
            tgt_req = violation_rob_idx + ROB_SEL'(1);
        end
    end

    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        tgt_d    = tgt_q;
        total_d  = total_q;
        walked_d = walked_q;
        slot1    = 1'b0;
        slot2    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    start_d  = rob_tail;
                    total_d  = n_req;
                    walked_d = '0;
                    tgt_d    = tgt_req;
                    state_d  = (n_req != '0) ? StWalk : StDone;
                end
            end
            StWalk: begin
                slot1    = walked_q < total_q;
                slot2    = (walked_q + (ROB_SEL+1)'(1)) < total_q;
                walked_d = walked_q + (ROB_SEL+1)'(slot1) + (ROB_SEL+1)'(slot2);
                if (req_any && n_req > total_q) begin
                    total_d = n_req;
                    tgt_d   = tgt_req;
                end
                if (walked_d >= total_d) state_d = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are suppressed in the reset cycle itself so nothing touches the rename map
    // once reset is seen.
    always_comb begin
        rd_idx_1        = '0;
        rd_idx_2        = '0;
        restore_valid_1 = 1'b0;
        restore_valid_2 = 1'b0;
        restore_arch_1  = '0;
        restore_arch_2  = '0;
        restore_phy_1   = '0;
        restore_phy_2   = '0;
        flush_valid_1   = 1'b0;
        flush_valid_2   = 1'b0;
        busy            = 1'b0;
        recover_done    = 1'b0;
        new_tail        = '0;
        flush_count     = '0;
        if (!reset && state_q == StWalk) begin
            busy            = 1'b1;
            rd_idx_1        = start_q + walked_q[ROB_SEL-1:0];
            rd_idx_2        = start_q + walked_q[ROB_SEL-1:0] + ROB_SEL'(1);
            restore_valid_1 = slot1;
            restore_valid_2 = slot2;
            flush_valid_1   = slot1;
            flush_valid_2   = slot2;
            if (slot1) begin
                restore_arch_1 = rd_dst_1;
                restore_phy_1  = rd_ori_1;
            end
            if (slot2) begin
                restore_arch_2 = rd_dst_2;
                restore_phy_2  = rd_ori_2;
            end
        end
        if (!reset && state_q == StDone) begin
            recover_done = 1'b1;
            new_tail     = tgt_q;
            flush_count  = total_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            start_q  <= '0;
            tgt_q    <= '0;
            total_q  <= '0;
            walked_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            tgt_q    <= tgt_d;
            total_q  <= total_d;
            walked_q <= walked_d;
        end
    end

endmodule

// File: tb/tb_rob_recovery_walker.sv
// tb_rob_recovery_walker
//   Scoreboard bench for rob_recovery_walker. Requests push the expected restore sequence and
//   completion report; a sampler at the falling edge pops and compares DUT output.
module tb_rob_recovery_walker;

    logic       clk = 1'b0;
    logic       reset;
    logic       prmiss, violation_detected;
    logic [5:0] prmiss_rob_idx, violation_rob_idx, rob_tail;
    logic [5:0] rd_idx_1, rd_idx_2;
    logic [4:0] rd_dst_1, rd_dst_2, restore_arch_1, restore_arch_2;
    logic [6:0] rd_ori_1, rd_ori_2, restore_phy_1, restore_phy_2;
    logic       restore_valid_1, restore_valid_2, flush_valid_1, flush_valid_2;
    logic       busy, recover_done;
    logic [5:0] new_tail;
    logic [6:0] flush_count;

    logic [4:0] rob_dst [64];
    logic [6:0] rob_ori [64];

    assign rd_dst_1 = rob_dst[rd_idx_1];
    assign rd_dst_2 = rob_dst[rd_idx_2];
    assign rd_ori_1 = rob_ori[rd_idx_1];
    assign rd_ori_2 = rob_ori[rd_idx_2];

    rob_recovery_walker dut (
        .clk               (clk),
        .reset             (reset),
        .prmiss            (prmiss),
        .prmiss_rob_idx    (prmiss_rob_idx),
        .violation_detected(violation_detected),
        .violation_rob_idx (violation_rob_idx),
        .rob_tail          (rob_tail),
        .rd_idx_1          (rd_idx_1),
        .rd_idx_2          (rd_idx_2),
        .rd_dst_1          (rd_dst_1),
        .rd_dst_2          (rd_dst_2),
        .rd_ori_1          (rd_ori_1),
        .rd_ori_2          (rd_ori_2),
        .restore_valid_1   (restore_valid_1),
        .restore_valid_2   (restore_valid_2),
        .restore_arch_1    (restore_arch_1),
        .restore_arch_2    (restore_arch_2),
        .restore_phy_1     (restore_phy_1),
        .restore_phy_2     (restore_phy_2),
        .flush_valid_1     (flush_valid_1),
        .flush_valid_2     (flush_valid_2),
        .busy              (busy),
        .recover_done      (recover_done),
        .new_tail          (new_tail),
        .flush_count       (flush_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] idx;
        logic [4:0] dst;
        logic [6:0] ori;
    } ent_t;

    typedef struct packed {
        logic [5:0]  tail;
        logic [6:0]  cnt;
        logic [31:0] cyc;
    } done_t;

    ent_t  exp_q[$];
    done_t done_q[$];

    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] cyc = 0;
    logic [5:0]  m_start;
    logic [6:0]  m_total;
    logic [31:0] m_req_cyc;
    logic [5:0]  last_tail;
    logic [6:0]  last_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic push_entry(input logic [5:0] i);
        ent_t e;
        e.idx = i;
        e.dst = rob_dst[i];
        e.ori = rob_ori[i];
        exp_q.push_back(e);
    endtask

    task automatic sample();
        ent_t  e;
        done_t d;
        if (restore_valid_1) begin
            if (exp_q.size() == 0) check("extra_restore_1", 32'(restore_valid_1), 0);
            else begin
                e = exp_q.pop_front();
                check("rd_idx_1", 32'(rd_idx_1), 32'(e.idx));
                check("arch_1", 32'(restore_arch_1), 32'(e.dst));
                check("phy_1", 32'(restore_phy_1), 32'(e.ori));
                check("flush_1", 32'(flush_valid_1), 1);
            end
        end else begin
            check("flush_1_idle", 32'(flush_valid_1), 0);
            check("restore_2_alone", 32'(restore_valid_2), 0);
        end
        if (restore_valid_2) begin
            if (exp_q.size() == 0) check("extra_restore_2", 32'(restore_valid_2), 0);
            else begin
                e = exp_q.pop_front();
                check("rd_idx_2", 32'(rd_idx_2), 32'(e.idx));
                check("arch_2", 32'(restore_arch_2), 32'(e.dst));
                check("phy_2", 32'(restore_phy_2), 32'(e.ori));
                check("flush_2", 32'(flush_valid_2), 1);
            end
        end else begin
            check("flush_2_idle", 32'(flush_valid_2), 0);
        end
        if (recover_done) begin
            if (done_q.size() == 0) check("extra_done", 32'(recover_done), 0);
            else begin
                d = done_q.pop_front();
                check("new_tail", 32'(new_tail), 32'(d.tail));
                check("flush_count", 32'(flush_count), 32'(d.cnt));
                check("done_cycle", cyc, d.cyc);
                last_tail = new_tail;
                last_cnt  = flush_count;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Drives one request for a single cycle from idle and records the expected walk.
    task automatic request(input logic p, input logic [5:0] pi, input logic v,
                           input logic [5:0] vi, input logic [5:0] tail);
        logic [6:0] np, nv, n;
        logic [5:0] tg, dd;
        done_t      d;
        dd = pi - tail;
        np = {1'b0, dd};
        dd = vi - tail;
        nv = {1'b0, dd} + 7'd1;
        if (p && (!v || np >= nv)) begin
            n  = np;
            tg = pi;
        end else begin
            n  = nv;
            tg = vi + 6'd1;
        end
        m_start   = tail;
        m_total   = n;
        m_req_cyc = cyc;
        for (int k = 0; k < 32'(n); k++) push_entry(tail + 6'(k));
        d.tail = tg;
        d.cnt  = n;
        d.cyc  = cyc + 32'((n + 7'd1) >> 1) + 1;
        done_q.push_back(d);
        prmiss             = p;
        prmiss_rob_idx     = pi;
        violation_detected = v;
        violation_rob_idx  = vi;
        rob_tail           = tail;
        tick();
        prmiss             = 1'b0;
        violation_detected = 1'b0;
    endtask

    // Older mispredict arriving while the walk is running.
    task automatic extend(input logic [5:0] pi);
        logic [5:0] dd;
        logic [6:0] n2;
        done_t      d;
        dd = pi - m_start;
        n2 = {1'b0, dd};
        if (n2 > m_total) begin
            for (int k = 32'(m_total); k < 32'(n2); k++) push_entry(m_start + 6'(k));
            d      = done_q[done_q.size()-1];
            d.tail = pi;
            d.cnt  = n2;
            d.cyc  = m_req_cyc + 32'((n2 + 7'd1) >> 1) + 1;
            done_q[done_q.size()-1] = d;
            m_total = n2;
        end
        prmiss         = 1'b1;
        prmiss_rob_idx = pi;
        tick();
        prmiss = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 200 && done_q.size() > 0; i++) tick();
        if (done_q.size() != 0) begin
            check({tag, "_timeout"}, done_q.size(), 0);
            done_q.delete();
        end
        check({tag, "_leftover"}, exp_q.size(), 0);
        exp_q.delete();
        check({tag, "_busy_after"}, 32'(busy), 0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rob_dst[i] = 5'($urandom);
            rob_ori[i] = 7'($urandom);
        end
        reset              = 1'b1;
        prmiss             = 1'b0;
        violation_detected = 1'b0;
        prmiss_rob_idx     = '0;
        violation_rob_idx  = '0;
        rob_tail           = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(recover_done), 0);
        check("rst_rd_idx_1", 32'(rd_idx_1), 0);
        check("rst_new_tail", 32'(new_tail), 0);
        check("rst_flush_count", 32'(flush_count), 0);

        // T1 basic mispredict
        request(1'b1, 6'd15, 1'b0, 6'd0, 6'd10);
        check("t1_busy", 32'(busy), 1);
        wait_done("t1");
        check("t1_tail", 32'(last_tail), 15);
        check("t1_cnt", 32'(last_cnt), 5);

        // T2 wrap-around walk
        request(1'b1, 6'd1, 1'b0, 6'd0, 6'd62);
        wait_done("t2");
        check("t2_tail", 32'(last_tail), 1);
        check("t2_cnt", 32'(last_cnt), 3);

        // T3 violation on the youngest entry
        request(1'b0, 6'd0, 1'b1, 6'd20, 6'd20);
        wait_done("t3");
        check("t3_tail", 32'(last_tail), 21);
        check("t3_cnt", 32'(last_cnt), 1);

        // T4 nothing to flush
        request(1'b1, 6'd7, 1'b0, 6'd0, 6'd7);
        check("t4_busy", 32'(busy), 0);
        wait_done("t4");
        check("t4_tail", 32'(last_tail), 7);
        check("t4_cnt", 32'(last_cnt), 0);

        // T5 simultaneous requests, then an older mispredict mid-walk
        request(1'b1, 6'd30, 1'b1, 6'd25, 6'd20);
        extend(6'd40);
        wait_done("t5");
        check("t5_tail", 32'(last_tail), 40);
        check("t5_cnt", 32'(last_cnt), 20);

        // Younger follow-up is ignored
        request(1'b0, 6'd0, 1'b1, 6'd12, 6'd3);
        extend(6'd6);
        wait_done("ign");
        check("ign_tail", 32'(last_tail), 13);
        check("ign_cnt", 32'(last_cnt), 10);

        // Violation one below the tail flushes the whole ROB
        request(1'b0, 6'd0, 1'b1, 6'd4, 6'd5);
        wait_done("full");
        check("full_tail", 32'(last_tail), 5);
        check("full_cnt", 32'(last_cnt), 64);

        // T6 reset in the second walk cycle
        request(1'b1, 6'd20, 1'b0, 6'd0, 6'd0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        done_q.delete();
        check("t6_busy", 32'(busy), 0);
        check("t6_rv1", 32'(restore_valid_1), 0);
        check("t6_fv1", 32'(flush_valid_1), 0);
        check("t6_rv2", 32'(restore_valid_2), 0);
        check("t6_done", 32'(recover_done), 0);
        for (int i = 0; i < 12; i++) tick();
        check("t6_busy_later", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
